step_gen_multi: RTL

//  N-axis coordinated stepper pulse generator; parametrised successor of the fixed 3-axis motor block.

---
 rtl/step_gen_multi.sv | 121 ++++++++++++
 1 files changed

// File: rtl/step_gen_multi.sv
// step_gen_multi: N-axis coordinated step/dir pulse generator.
// Handles dir setup delay, per-axis periods, pause at period boundaries, abort and min-period clamping.
module step_gen_multi #(
    parameter int N_AXIS    = 3,
    parameter int DIS_W     = 11,
    parameter int PER_W     = 26,
    parameter int PULSE_W   = 4,
    parameter int SETUP_CYC = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [N_AXIS*DIS_W-1:0] cmd_dist,
    input  logic [N_AXIS*PER_W-1:0] cmd_per,
    input  logic [N_AXIS-1:0]       cmd_dir,
    input  logic                    pause,
    input  logic                    abort,
    output logic [N_AXIS-1:0]       step,
    output logic [N_AXIS-1:0]       dir,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic [1:0]              state
);
    localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, RUN = 2'd2, DONE = 2'd3;
    localparam int SC_W = $clog2(SETUP_CYC + 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETUP_CYC - 1);
    localparam logic [PER_W:0] MIN_PE = (PER_W+1)'(2 * PULSE_W);
    localparam logic [PER_W:0] PW = (PER_W+1)'(PULSE_W);
    localparam logic [PER_W:0] ONE = (PER_W+1)'(1);

    logic [1:0]        state_q, state_d;
    logic [SC_W-1:0]   scnt_q, scnt_d;
    logic [DIS_W-1:0]  rem_q [N_AXIS];
    logic [DIS_W-1:0]  rem_r [N_AXIS];
    logic [DIS_W-1:0]  rem_d [N_AXIS];
    logic [PER_W:0]    cnt_q [N_AXIS];
    logic [PER_W:0]    cnt_r [N_AXIS];
    logic [PER_W:0]    cnt_d [N_AXIS];
    logic [PER_W:0]    pe_q [N_AXIS];
    logic [PER_W:0]    pe_d [N_AXIS];
    logic [N_AXIS-1:0] hold_q, hold_d, step_q, step_d, dir_q, dir_d;
    logic              done_q, aborted_q, accept, rem_q_zero, rem_r_zero;

    // Free-running advance of each axis as if the move carries on; held axes sit at cnt=0.
    always_comb begin
        rem_q_zero = 1'b1;
        rem_r_zero = 1'b1;
        for (int i = 0; i < N_AXIS; i++) begin
            rem_r[i] = (rem_q[i] != '0 && !hold_q[i] && cnt_q[i] == pe_q[i] - ONE) ? rem_q[i] - DIS_W'(1) : rem_q[i];
            cnt_r[i] = (rem_q[i] == '0 || hold_q[i] || cnt_q[i] == pe_q[i] - ONE) ? '0 : cnt_q[i] + ONE;
            rem_q_zero &= rem_q[i] == '0;
            rem_r_zero &= rem_r[i] == '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = cmd_valid ? SETUP : IDLE;
            SETUP:   state_d = abort ? IDLE : (scnt_q != SC_LAST) ? SETUP : rem_q_zero ? DONE : RUN;
            RUN:     state_d = abort ? IDLE : rem_r_zero ? DONE : RUN;
            default: state_d = IDLE;
        endcase
    end

    // Step is registered from next-state counters so it lines up with cnt in the same cycle.
    always_comb begin
        accept = state_q == IDLE && cmd_valid;
        scnt_d = (state_q == SETUP && state_d == SETUP) ? scnt_q + SC_W'(1) : '0;
        dir_d = accept ? cmd_dir : dir_q;
        for (int i = 0; i < N_AXIS; i++) begin
            rem_d[i] = accept ? cmd_dist[i*DIS_W +: DIS_W] : (state_d == SETUP || state_d == RUN) ? rem_r[i] : '0;
            cnt_d[i] = (state_q == RUN && state_d == RUN) ? cnt_r[i] : '0;
            pe_d[i] = !accept ? pe_q[i] : ({1'b0, cmd_per[i*PER_W +: PER_W]} < MIN_PE) ? MIN_PE : {1'b0, cmd_per[i*PER_W +: PER_W]};
            hold_d[i] = state_d == RUN && cnt_d[i] == '0 && pause;
            step_d[i] = state_d == RUN && rem_d[i] != '0 && cnt_d[i] < PW && !hold_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            scnt_q <= '0;
            hold_q <= '0;
            step_q <= '0;
            dir_q <= '0;
            done_q <= 1'b0;
            aborted_q <= 1'b0;
            for (int i = 0; i < N_AXIS; i++) begin
                rem_q[i] <= '0;
                cnt_q[i] <= '0;
                pe_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            scnt_q <= scnt_d;
            hold_q <= hold_d;
            step_q <= step_d;
            dir_q <= dir_d;
            done_q <= state_d == DONE;
            aborted_q <= abort && (state_q == SETUP || state_q == RUN);
            for (int i = 0; i < N_AXIS; i++) begin
                rem_q[i] <= rem_d[i];
                cnt_q[i] <= cnt_d[i];
                pe_q[i] <= pe_d[i];
            end
        end
    end

    always_comb begin
        cmd_ready = state_q == IDLE;
        busy = state_q != IDLE;
        state = state_q;
        step = step_q;
        dir = dir_q;
        done = done_q;
        aborted = aborted_q;
    end
endmodule
